vga_rx: RTL and testbench

VGA_RX -- requirements
Module: vga_rx

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_edge_det.sv | 28 ++
 rtl/vga_rx.sv | 163 ++++++++++++++++
 tb/tb_vga_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (nominal 640x480 @ 60 Hz with a 50 MHz clock)
// and the receiver FSM state type.
package vga_pkg;

  localparam int unsigned HTotalClk    = 1600;
  localparam int unsigned HSyncClk     = 192;
  localparam int unsigned HStartClk    = 288;
  localparam int unsigned HActivePix   = 640;
  localparam int unsigned ClkPerPix    = 2;
  localparam int unsigned VTotalLines  = 525;
  localparam int unsigned VStartLine   = 35;
  localparam int unsigned VActiveLines = 480;

  typedef enum logic [1:0] {
    StSearch,
    StMeasure,
    StLocked
  } rx_state_e;

endpackage

// File: rtl/vga_edge_det.sv
// Registers a single-bit input once and flags its rising/falling edges by
// comparing the registered value against the previous registered value.
module vga_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic sync_q;
  logic prev_q;

  // Input register plus one-cycle history for edge comparison
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= d;
      prev_q <= sync_q;
    end
  end

  assign rise = ~prev_q & sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: locks onto incoming hsync/vsync timing, emits one strobe per
// visible pixel with its coordinates and colour, and checksums each frame.
module vga_rx
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL_CLK = HTotalClk,
  parameter int unsigned H_SYNC_CLK  = HSyncClk,
  parameter int unsigned H_START_CLK = HStartClk,
  parameter int unsigned H_ACTIVE    = HActivePix,
  parameter int unsigned CLK_PER_PIX = ClkPerPix,
  parameter int unsigned V_TOTAL     = VTotalLines,
  parameter int unsigned V_START     = VStartLine,
  parameter int unsigned V_ACTIVE    = VActiveLines
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [15:0] frame_cnt,
  output logic        h_err,
  output logic        v_err
);

  localparam logic [10:0] CntMax = 11'h7FF;
  localparam logic [10:0] HLast  = 11'(H_TOTAL_CLK - 1);
  localparam logic [10:0] HSyncW = 11'(H_SYNC_CLK);
  localparam logic [10:0] HBeg   = 11'(H_START_CLK);
  localparam logic [10:0] HEnd   = 11'(H_START_CLK + H_ACTIVE * CLK_PER_PIX);
  localparam logic [10:0] HStep  = 11'(CLK_PER_PIX);
  localparam logic [10:0] VLast  = 11'(V_TOTAL - 1);
  localparam logic [10:0] VBeg   = 11'(V_START);
  localparam logic [10:0] VEnd   = 11'(V_START + V_ACTIVE);

  logic        hs_rise, hs_fall, vs_fall, unused_vs_rise;
  logic [10:0] hcnt_q, vcnt_q, h_cur, v_cur;
  logic        line_seen_q, varm_q;
  logic [11:0] rgb_q;
  logic [15:0] sum_q;
  logic        h_err_c, v_err_c, sample_c;
  rx_state_e   state_q;

  vga_edge_det u_hs_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (hsync),
    .rise (hs_rise),
    .fall (hs_fall)
  );

  vga_edge_det u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (vsync),
    .rise (unused_vs_rise),
    .fall (vs_fall)
  );

  // Counts for the sample currently in rgb_q, plus error and sample decisions
  always_comb begin
    h_cur = hs_fall ? 11'd0 : ((hcnt_q == CntMax) ? hcnt_q : hcnt_q + 11'd1);
    v_cur = vcnt_q;
    if (hs_fall) begin
      // A vsync fall coinciding with the hsync fall starts line 0 immediately
      v_cur = (varm_q || vs_fall) ? 11'd0 : ((vcnt_q == CntMax) ? vcnt_q : vcnt_q + 11'd1);
    end
    h_err_c = line_seen_q && ((hs_fall && (hcnt_q != HLast)) ||
                              (hs_rise && (h_cur != HSyncW)));
    v_err_c = vs_fall && (state_q != StSearch) && (vcnt_q != VLast);
    sample_c = (state_q == StLocked) && (h_cur >= HBeg) && (h_cur < HEnd) &&
               (((h_cur - HBeg) % HStep) == 11'd0) && (v_cur >= VBeg) && (v_cur < VEnd);
  end

  // Timing counters, input colour register, pixel output pipeline and checksum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      line_seen_q <= 1'b0;
      varm_q      <= 1'b0;
      rgb_q       <= '0;
      sum_q       <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
    end else begin
      hcnt_q      <= h_cur;
      vcnt_q      <= v_cur;
      line_seen_q <= line_seen_q | hs_fall;
      varm_q      <= hs_fall ? 1'b0 : (varm_q | vs_fall);
      rgb_q       <= {red, green, blue};
      pix_valid   <= sample_c;
      if (sample_c) begin
        pix_x   <= 10'((h_cur - HBeg) / HStep);
        pix_y   <= 10'(v_cur - VBeg);
        pix_rgb <= rgb_q;
      end
      if (vs_fall) begin
        sum_q <= '0;
      end else if (sample_c) begin
        sum_q <= sum_q + {4'h0, rgb_q};
      end
    end
  end

  // Lock FSM with registered status, error pulses and per-frame results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StSearch;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      frame_cnt  <= '0;
      h_err      <= 1'b0;
      v_err      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      h_err      <= h_err_c;
      v_err      <= v_err_c;
      unique case (state_q)
        StSearch: begin
          if (vs_fall && !h_err_c) begin
            state_q <= StMeasure;
          end
        end
        StMeasure: begin
          if (h_err_c || v_err_c) begin
            state_q <= StSearch;
          end else if (vs_fall) begin
            state_q <= StLocked;
            locked  <= 1'b1;
          end
        end
        StLocked: begin
          // An error in the same cycle as vsync fall discards the frame
          if (h_err_c || v_err_c) begin
            state_q <= StSearch;
            locked  <= 1'b0;
          end else if (vs_fall) begin
            frame_done <= 1'b1;
            frame_sum  <= sum_q;
            frame_cnt  <= frame_cnt + 16'd1;
          end
        end
        default: begin
          state_q <= StSearch;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rx.sv
// Bench for vga_rx: a scaled-down VGA source with random pixel colours, and a
// frame-level model of lock state, expected pixels and frame checksums.
module tb_vga_rx;

  localparam int unsigned HT  = 40;
  localparam int unsigned HS  = 4;
  localparam int unsigned HST = 8;
  localparam int unsigned HA  = 12;
  localparam int unsigned CPP = 2;
  localparam int unsigned VT  = 20;
  localparam int unsigned VSL = 2;
  localparam int unsigned VST = 3;
  localparam int unsigned VA  = 12;

  logic        clk, rst, hsync, vsync;
  logic [3:0]  red, green, blue;
  logic        locked, pix_valid, frame_done, h_err, v_err;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_rgb;
  logic [15:0] frame_sum, frame_cnt;

  vga_rx #(
    .H_TOTAL_CLK (HT),
    .H_SYNC_CLK  (HS),
    .H_START_CLK (HST),
    .H_ACTIVE    (HA),
    .CLK_PER_PIX (CPP),
    .V_TOTAL     (VT),
    .V_START     (VST),
    .V_ACTIVE    (VA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hsync      (hsync),
    .vsync      (vsync),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .locked     (locked),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_done (frame_done),
    .frame_sum  (frame_sum),
    .frame_cnt  (frame_cnt),
    .h_err      (h_err),
    .v_err      (v_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  int          stage      = 0;  // 0 searching, 1 measuring, 2 locked
  int          fcnt       = 0;
  logic [15:0] fsum       = '0;
  int          prev_lines = 0;
  bit          prev_short = 0;
  int          herr_exp   = 0;
  int          verr_exp   = 0;
  int          herr_seen  = 0;
  int          verr_seen  = 0;
  logic [31:0] exp_pix[$];   // {x, y, rgb}
  logic [31:0] exp_done[$];  // {sum, cnt}
  logic [31:0] e;

  // Output monitor: compares every strobe against the model's queues
  always @(negedge clk) begin
    if (h_err) herr_seen++;
    if (v_err) verr_seen++;
    if (pix_valid) begin
      if (exp_pix.size() == 0) begin
        check_eq("pix_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_pix.pop_front();
        check_eq("pix_x", 32'(pix_x), 32'(e[31:22]));
        check_eq("pix_y", 32'(pix_y), 32'(e[21:12]));
        check_eq("pix_rgb", 32'(pix_rgb), 32'(e[11:0]));
      end
    end
    if (frame_done) begin
      if (exp_done.size() == 0) begin
        check_eq("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_done.pop_front();
        check_eq("frame_sum", 32'(frame_sum), 32'(e[31:16]));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(e[15:0]));
      end
    end
  end

  task automatic drive_clk(input logic hs, input logic vs, input logic [11:0] rgb);
    @(negedge clk);
    hsync = hs;
    vsync = vs;
    {red, green, blue} = rgb;
  endtask

  // mode: 0 random, 1 solid red, 2 single white pixel at the last position
  task automatic send_frame(input int n_lines, input int short_line, input int mode,
                            input int rst_line);
    int          len, x, y;
    bit          vis;
    logic [11:0] cur;
    cur = '0;
    for (int l = 0; l < n_lines; l++) begin
      len = (l == short_line) ? HT - 2 : HT;
      if (prev_short) begin
        herr_exp++;
        stage = 0;
      end else if (l == 0) begin
        if (stage > 0 && prev_lines != VT) begin
          verr_exp++;
          stage = 0;
        end else if (stage == 2) begin
          fcnt = (fcnt + 1) % 65536;
          exp_done.push_back({fsum, 16'(fcnt)});
        end else begin
          stage++;
        end
      end
      if (l == 0) fsum = '0;
      prev_short = (l == short_line);
      for (int c = 0; c < len; c++) begin
        vis = (l >= VST) && (l < VST + VA) && (c >= HST) && (c < HST + HA * CPP);
        if (vis && ((c - HST) % CPP == 0)) begin
          x = (c - HST) / CPP;
          y = l - VST;
          case (mode)
            1:       cur = 12'hF00;
            2:       cur = (x == HA - 1 && y == VA - 1) ? 12'hFFF : 12'h000;
            default: cur = 12'($urandom);
          endcase
          if (stage == 2) begin
            exp_pix.push_back({10'(x), 10'(y), cur});
            fsum = fsum + 16'(cur);
          end
        end
        drive_clk(c >= HS, l >= VSL, vis ? cur : 12'h000);
        if (l == rst_line && c == 0) begin
          #2 rst = 1'b1;
          #1;
          check_eq("rst_locked", 32'(locked), 32'd0);
          check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
          check_eq("rst_frame_sum", 32'(frame_sum), 32'd0);
          check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
          stage = 0;
          fcnt  = 0;
        end
        if (l == rst_line && c == 3) rst = 1'b0;
        if (c == 20) begin
          check_eq("locked", 32'(locked), 32'(stage == 2));
          check_eq("h_err_count", 32'(herr_seen), 32'(herr_exp));
          check_eq("v_err_count", 32'(verr_seen), 32'(verr_exp));
        end
      end
    end
    prev_lines = n_lines;
  endtask

  initial begin
    int short_a, rst_l;
    rst   = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    {red, green, blue} = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_locked", 32'(locked), 32'd0);
    check_eq("reset_pix_valid", 32'(pix_valid), 32'd0);
    check_eq("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("reset_frame_sum", 32'(frame_sum), 32'd0);
    check_eq("reset_errs", 32'({h_err, v_err, frame_done}), 32'd0);
    rst = 1'b0;
    repeat (10) drive_clk(1'b1, 1'b1, 12'h000);

    short_a = int'($urandom_range(18, 1));
    rst_l   = int'($urandom_range(15, 5));

    send_frame(VT, -1, 0, -1);       // first vsync fall: measuring
    send_frame(VT, -1, 0, -1);       // second: locked
    send_frame(VT, -1, 1, -1);       // solid red frame
    send_frame(VT, -1, 2, -1);       // single white pixel frame
    send_frame(VT, -1, 0, -1);
    send_frame(VT, short_a, 0, -1);  // short line while locked
    send_frame(VT, -1, 0, -1);
    send_frame(VT, -1, 0, -1);
    send_frame(VT - 1, -1, 0, -1);   // one line missing
    send_frame(VT, -1, 0, -1);       // v_err at its vsync fall
    send_frame(VT, -1, 0, -1);
    send_frame(VT, -1, 0, -1);
    send_frame(VT, -1, 0, rst_l);    // reset mid-frame
    send_frame(VT, -1, 0, -1);
    send_frame(VT, -1, 0, -1);
    send_frame(VT, -1, 0, -1);
    send_frame(VT, VT - 1, 0, -1);   // short last line: h_err coincides with vsync fall
    send_frame(VT, -1, 0, -1);
    send_frame(VT, -1, 0, -1);
    send_frame(VT, -1, 0, -1);
    send_frame(VT, -1, 0, -1);

    repeat (20) drive_clk(1'b1, 1'b1, 12'h000);
    check_eq("pix_left", 32'(exp_pix.size()), 32'd0);
    check_eq("done_left", 32'(exp_done.size()), 32'd0);
    check_eq("h_err_total", 32'(herr_seen), 32'(herr_exp));
    check_eq("v_err_total", 32'(verr_seen), 32'(verr_exp));
    check_eq("final_frame_cnt", 32'(frame_cnt), 32'(fcnt));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
